// File: rtl/fifo_flag_src.sv
// fifo_flag_src
//   Flag-producing FIFO that sits opposite the flow-control FSM. It buffers
//   data words and generates the FSM's status inputs (empty / not-empty /
//   almost-full / almost-empty / sticky overflow). The FSM's pausa/continua
//   outputs stall and resume the read side, and its init pulse reloads the
//   almost-full / almost-empty thresholds.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   init                load thresholds, clear overflow, enter RUN
//   umbral_af/_ae       thresholds sampled on init
//   push, data_in       write request and data
//   pop                 read request (honoured only in RUN)
//   pausa, continua     stall / resume read side
//   data_Fifo,valid_out registered read data, valid one cycle after pop
//   empty_Fifo, no_empty_Fifo, almost_full, almost_empty, Fifo_overflow
//                       status flags decoded from the registered count

module fifo_flag_src #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_DEFAULT = 6,
    parameter int AE_DEFAULT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH:0]   umbral_af,
    input  logic [ADDR_WIDTH:0]   umbral_ae,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic                  pausa,
    input  logic                  continua,
    output logic [DATA_WIDTH-1:0] data_Fifo,
    output logic                  valid_out,
    output logic                  empty_Fifo,
    output logic                  no_empty_Fifo,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  Fifo_overflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   AF_DEF  = (ADDR_WIDTH+1)'(AF_DEFAULT);
    localparam logic [ADDR_WIDTH:0]   AE_DEF  = (ADDR_WIDTH+1)'(AE_DEFAULT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   af_thr, ae_thr;
    logic [ADDR_WIDTH:0]   af_ld, ae_ld;

    logic rd_acc, wr_acc, ovf_evt, side_on;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (init) begin
            // init wins over pausa/continua from any state
            state_nxt = RUN;
        end else begin
            unique case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     if (pausa) state_nxt = PAUSED;
                PAUSED:  if (continua && !pausa) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Accept logic
    // ------------------------------------------------------------------
    // Writes are live in RUN and PAUSED; only the read side stalls.
    assign side_on = (state != IDLE);
    assign rd_acc  = pop && (state == RUN) && (count != '0);
    // A same-cycle read frees a slot, so a full FIFO still takes the word.
    assign wr_acc  = push && side_on && ((count != DEPTH_C) || rd_acc);
    assign ovf_evt = push && side_on && (count == DEPTH_C) && !rd_acc;

    // ------------------------------------------------------------------
    // Threshold load decode
    // ------------------------------------------------------------------
    always_comb begin
        af_ld = AF_DEF;
        ae_ld = AE_DEF;
        if ((umbral_af != '0) && (umbral_af <= DEPTH_C)) af_ld = umbral_af;
        // ae is compared against the raw af request, not the decoded one
        if (umbral_ae < umbral_af) ae_ld = umbral_ae;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            af_thr <= AF_DEF;
            ae_thr <= AE_DEF;
        end else if (init) begin
            af_thr <= af_ld;
            ae_thr <= ae_ld;
        end
    end

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read data register: one-cycle latency, holds when no read
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            data_Fifo <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= rd_acc;
            if (rd_acc) data_Fifo <= mem[rd_ptr];
        end
    end

    // ------------------------------------------------------------------
    // Sticky overflow; init clears it even if a drop happens that cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)        Fifo_overflow <= 1'b0;
        else if (init)    Fifo_overflow <= 1'b0;
        else if (ovf_evt) Fifo_overflow <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Status flags straight from the registered count
    // ------------------------------------------------------------------
    assign empty_Fifo    = (count == '0);
    assign no_empty_Fifo = !empty_Fifo;
    assign almost_full   = (count >= af_thr);
    assign almost_empty  = (count != '0) && (count <= ae_thr);

endmodule
